spi_slave_responder: RTL and testbench

// - SPI responder (slave), mode 0 (CPOL=0, CPHA=0), MSB first, fixed word length.
// - Sits on the far end of the Nios II spi_0 master bus: it receives MOSI words and returns MISO words.
// - Use cases: ADC stand-in for board bring-up and a loopback target for the spi_0 driver.
// - Single system clock. The SCLK, SS_n and MOSI inputs are oversampled; SCLK is never used as a clock.

---
 rtl/spi_slave_pkg.sv | 19 +
 rtl/spi_in_sync.sv | 32 +++
 rtl/spi_slave_responder.sv | 169 ++++++++++++++++
 tb/tb_spi_slave_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI mode-0 responder.
// The state encoding is used by the top-level FSM; cnt_w sizes the bit counter.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Counter must be able to hold the full word length itself, not just length-1.
  function automatic int cnt_w(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall strobes
// derived from a registered copy of the synchronized value.
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  // Chain resets low so a pin already low at reset release never produces a fall strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_q    = r_chain[STAGES-1];
  assign o_rise = r_chain[STAGES-1] & ~r_prev;
  assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder with oversampled SCLK/SS_n/MOSI, a one-entry tx holding
// register and back-to-back word support under a single slave select.
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] TX_DEFAULT  = '0,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  spi_sclk,
  input  logic                  spi_ss_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int              CNT_W    = cnt_w(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  logic w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic w_ss_s, w_ss_rise, w_ss_fall;
  logic w_mosi_s;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-2:0] r_tx_shift;
  logic [DATA_WIDTH-2:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic                  r_miso, r_miso_oe;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid, r_frame_err;
  logic                  r_ss_armed;

  logic w_load, w_reload, w_word_start, w_tx_step, w_rx_step, w_exit, w_frame_err, w_accept;
  logic [DATA_WIDTH-1:0] w_tx_next;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .i_d    (spi_sclk),
    .o_q    (w_sclk_s),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .i_d    (spi_ss_n),
    .o_q    (w_ss_s),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_mosi_sync <= '0;
    else                r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  // A frame only starts with SCLK at its idle level; ss_rise always wins over SCLK edges.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall && (w_sclk_s == SPI_CPOL)) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = w_ss_rise ? IDLE : SHIFT;
      SHIFT:   if (w_ss_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_load      = (r_state == LOAD) && !w_ss_rise;
    w_exit      = (r_state != IDLE) && w_ss_rise;
    w_frame_err = (r_state == SHIFT) && w_ss_rise && (r_cnt != '0) && (r_cnt != CNT_FULL);
    w_rx_step   = (r_state == SHIFT) && !w_ss_rise && w_sclk_rise && (r_cnt != CNT_FULL);
    w_reload    = (r_state == SHIFT) && !w_ss_rise && w_sclk_fall && (r_cnt == CNT_FULL);
    w_tx_step   = (r_state == SHIFT) && !w_ss_rise && w_sclk_fall &&
                  (r_cnt != '0) && (r_cnt != CNT_FULL);
    w_word_start = w_load || w_reload;
    w_tx_next    = r_hold_full ? r_hold : TX_DEFAULT;
    w_accept     = tx_valid && !r_hold_full;
  end

  // Word start consumes the entry first; a same-cycle accept then refills it.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_word_start) r_hold_full <= 1'b0;
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cnt       <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= w_frame_err;
      if (w_word_start) begin
        r_tx_shift <= w_tx_next[DATA_WIDTH-2:0];
        r_miso     <= w_tx_next[DATA_WIDTH-1];
        r_rx_shift <= '0;
        r_cnt      <= '0;
      end else if (w_tx_step) begin
        r_miso     <= r_tx_shift[DATA_WIDTH-2];
        r_tx_shift <= {r_tx_shift[DATA_WIDTH-3:0], 1'b0};
      end
      if (w_load) r_miso_oe <= 1'b1;
      if (w_rx_step) begin
        r_rx_shift <= {r_rx_shift[DATA_WIDTH-3:0], w_mosi_s};
        r_cnt      <= r_cnt + 1'b1;
        if (r_cnt == CNT_FULL - 1'b1) begin
          r_rx_data  <= {r_rx_shift, w_mosi_s};
          r_rx_valid <= 1'b1;
        end
      end
      if (w_exit) begin
        r_miso_oe <= 1'b0;
        r_miso    <= 1'b0;
        r_cnt     <= '0;
      end
    end
  end

  // busy stays low until SS_n has been seen high once, so a frame in flight at reset release is ignored.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  r_ss_armed <= 1'b0;
    else if (w_ss_s)     r_ss_armed <= 1'b1;
  end

  assign busy        = r_ss_armed & ~w_ss_s;
  assign tx_ready    = ~r_hold_full;
  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Scoreboard bench for spi_slave_responder: directed SPI frames at clk/8,
// expected rx words, master-captured MISO words and frame errors queued by stimulus.
module tb_spi_slave_responder;

  localparam int DW = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          ss_n = 1'b1;
  logic          mosi = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          miso, oe, tx_ready, rx_valid, frame_err, busy;
  logic [DW-1:0] rx_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_rx[$];
  logic [DW-1:0] exp_miso[$];
  logic [DW-1:0] got_miso[$];
  int            exp_err[$];

  spi_slave_responder #(
    .DATA_WIDTH (DW),
    .TX_DEFAULT (16'hDEAD),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .spi_sclk     (sclk),
    .spi_ss_n     (ss_n),
    .spi_mosi     (mosi),
    .spi_miso     (miso),
    .spi_miso_oe  (oe),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event", name);
  endtask

  // Monitor: compares every DUT-presented output against the queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) flag_fail("rx_valid_unexpected");
        else check("rx_data", rx_data, exp_rx.pop_front());
      end
      if (frame_err) begin
        if (exp_err.size() == 0) flag_fail("frame_err_unexpected");
        else check("frame_err", frame_err, exp_err.pop_front());
      end
      if (got_miso.size() != 0) begin
        if (exp_miso.size() == 0) flag_fail("miso_word_unexpected");
        else check("miso_word", got_miso.pop_front(), exp_miso.pop_front());
      end
    end
  end

  task automatic tx_send(input logic [DW-1:0] d);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_ready) begin
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        return;
      end
    end
    flag_fail("tx_send_timeout");
  endtask

  task automatic ss_low();
    @(negedge clk);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // mo is left-aligned: bit i of the frame is mo[31-i]; each full 16-bit MISO word is recorded.
  task automatic shift_bits(input int nbits, input logic [31:0] mo);
    logic [DW-1:0] cap;
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[31-i];
      repeat (4) @(negedge clk);
      cap  = {cap[DW-2:0], miso};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      if (i % DW == DW - 1) got_miso.push_back(cap);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("tx_ready_after_release", tx_ready, 1);

    // Single word with queued tx
    tx_send(16'h3C0F);
    check("tx_ready_hold_full", tx_ready, 0);
    exp_rx.push_back(16'hA55A);
    exp_miso.push_back(16'h3C0F);
    ss_low();
    check("miso_oe_active", oe, 1);
    check("busy_active", busy, 1);
    shift_bits(16, {16'hA55A, 16'h0000});
    ss_high();
    check("miso_oe_after_frame", oe, 0);
    check("busy_after_frame", busy, 0);

    // Underrun
    exp_rx.push_back(16'h0F0F);
    exp_miso.push_back(16'hDEAD);
    ss_low();
    shift_bits(16, {16'h0F0F, 16'h0000});
    ss_high();

    // Burst: second word queued while the first is in flight
    tx_send(16'h1111);
    exp_rx.push_back(16'h1234);
    exp_rx.push_back(16'hABCD);
    exp_miso.push_back(16'h1111);
    exp_miso.push_back(16'h2222);
    ss_low();
    fork
      shift_bits(32, 32'h1234_ABCD);
      begin
        repeat (40) @(negedge clk);
        tx_send(16'h2222);
      end
    join
    ss_high();

    // Abort after 5 SCLKs
    exp_err.push_back(1);
    ss_low();
    shift_bits(5, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    check("oe_before_abort", oe, 1);
    ss_n = 1'b1;
    repeat (SS + 2) @(negedge clk);
    check("oe_after_abort", oe, 0);
    check("rx_data_kept_after_abort", rx_data, 16'hABCD);
    repeat (8) @(negedge clk);

    // Accept lands on the LOAD cycle: word 1 uses empty hold (default), word 2 the new value
    exp_rx.push_back(16'h0001);
    exp_rx.push_back(16'h8000);
    exp_miso.push_back(16'hDEAD);
    exp_miso.push_back(16'h5A5A);
    fork
      begin
        ss_low();
        shift_bits(32, 32'h0001_8000);
        ss_high();
      end
      begin
        @(negedge ss_n);
        repeat (3) @(posedge clk);
        @(negedge clk);
        tx_data  = 16'h5A5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join

    // Asynchronous reset in the middle of a frame
    tx_send(16'h7777);
    ss_low();
    tx_send(16'h8888);
    shift_bits(3, 32'hE000_0000);
    check("pre_reset_oe", oe, 1);
    check("pre_reset_tx_ready", tx_ready, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_miso", miso, 0);
    check("midrst_miso_oe", oe, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    shift_bits(8, 32'hFF00_0000);
    check("ignored_frame_oe", oe, 0);
    check("ignored_frame_busy", busy, 0);
    check("ignored_frame_tx_ready", tx_ready, 1);
    ss_high();

    tx_send(16'h0F0F);
    exp_rx.push_back(16'hC3C3);
    exp_miso.push_back(16'h0F0F);
    ss_low();
    shift_bits(16, {16'hC3C3, 16'h0000});
    ss_high();

    repeat (20) @(negedge clk);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("miso_queue_drained", exp_miso.size(), 0);
    check("err_queue_drained", exp_err.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
